// File: rtl/riscv_core_rob_mp.sv
// rtl/riscv_core_rob_mp.sv - reorder buffer with multi-port writeback fill, in-order commit and operand lookup
module riscv_core_rob_mp #(
    parameter int SLOTS = 16,
    parameter int LOG_S = 4,
    parameter int DW    = 32,
    parameter int NFILL = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   alloc_val_i,
    output logic                   alloc_rdy_o,
    input  logic                   alloc_wen_i,
    input  logic [4:0]             alloc_waddr_i,
    output logic [LOG_S-1:0]       alloc_slot_o,
    input  logic [NFILL-1:0]       fill_val_i,
    input  logic [NFILL*LOG_S-1:0] fill_slot_i,
    input  logic [NFILL*DW-1:0]    fill_data_i,
    input  logic                   commit_rdy_i,
    output logic                   commit_val_o,
    output logic                   commit_wen_o,
    output logic [4:0]             commit_waddr_o,
    output logic [LOG_S-1:0]       commit_slot_o,
    output logic [DW-1:0]          commit_data_o,
    input  logic [4:0]             lk_raddr0_i,
    input  logic [4:0]             lk_raddr1_i,
    output logic                   lk_hit0_o,
    output logic                   lk_hit1_o,
    output logic                   lk_rdy0_o,
    output logic                   lk_rdy1_o,
    output logic [LOG_S-1:0]       lk_slot0_o,
    output logic [LOG_S-1:0]       lk_slot1_o,
    output logic [DW-1:0]          lk_data0_o,
    output logic [DW-1:0]          lk_data1_o,
    input  logic                   flush_i,
    output logic [LOG_S:0]         count_o,
    output logic                   empty_o
);

    // Control state (reset) and per-slot payload (not reset)
    logic [LOG_S-1:0] head_q, head_d;
    logic [LOG_S-1:0] tail_q, tail_d;
    logic [LOG_S:0]   count_q, count_d;
    logic [SLOTS-1:0] valid_q, valid_d;
    logic [SLOTS-1:0] pending_q, pending_d;
    logic [SLOTS-1:0] wen_q;
    logic [4:0]       waddr_q [SLOTS];
    logic [DW-1:0]    data_q  [SLOTS];

    logic             alloc_go;
    logic             commit_go;
    logic [SLOTS-1:0] fill_we;
    logic [DW-1:0]    fill_wdata [SLOTS];

    logic [4:0]       lk_raddr [2];
    logic             lk_hit   [2];
    logic [LOG_S-1:0] lk_slot  [2];

    // Handshakes only look at registered state, so a same-cycle commit never frees a slot
    assign alloc_rdy_o  = (count_q != (LOG_S+1)'(SLOTS));
    assign alloc_slot_o = tail_q;
    assign commit_val_o = valid_q[head_q] && !pending_q[head_q];
    assign commit_wen_o   = wen_q[head_q];
    assign commit_waddr_o = waddr_q[head_q];
    assign commit_slot_o  = head_q;
    assign commit_data_o  = data_q[head_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

    assign alloc_go  = alloc_val_i && alloc_rdy_o && !flush_i;
    assign commit_go = commit_val_o && commit_rdy_i && !flush_i;

    // Writeback fills: later ports override earlier ones; fills to empty or just-allocated slots drop
    always_comb begin
        fill_we = '0;
        for (int s = 0; s < SLOTS; s++) begin
            fill_wdata[s] = '0;
        end
        for (int s = 0; s < SLOTS; s++) begin
            for (int i = 0; i < NFILL; i++) begin
                if (!flush_i && fill_val_i[i] &&
                    fill_slot_i[i*LOG_S +: LOG_S] == LOG_S'(s) &&
                    valid_q[s] && !(alloc_go && tail_q == LOG_S'(s))) begin
                    fill_we[s]    = 1'b1;
                    fill_wdata[s] = fill_data_i[i*DW +: DW];
                end
            end
        end
    end

    // Next-state for pointers, occupancy and per-slot status bits; flush overrides everything
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        valid_d   = valid_q;
        pending_d = pending_q;
        if (flush_i) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            valid_d   = '0;
            pending_d = '0;
        end else begin
            pending_d = pending_q & ~fill_we;
            if (commit_go) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + LOG_S'(1);
            end
            if (alloc_go) begin
                valid_d[tail_q]   = 1'b1;
                pending_d[tail_q] = 1'b1;
                tail_d            = tail_q + LOG_S'(1);
            end
            count_d = count_q + (LOG_S+1)'(alloc_go) - (LOG_S+1)'(commit_go);
        end
    end

    // Control registers with asynchronous clear
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            valid_q   <= '0;
            pending_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
        end
    end

    // Payload arrays: only meaningful while the slot is valid, so they carry no reset
    always_ff @(posedge clk_i) begin
        if (alloc_go) begin
            wen_q[tail_q]   <= alloc_wen_i;
            waddr_q[tail_q] <= alloc_waddr_i;
        end
        for (int s = 0; s < SLOTS; s++) begin
            if (fill_we[s]) begin
                data_q[s] <= fill_wdata[s];
            end
        end
    end

    assign lk_raddr[0] = lk_raddr0_i;
    assign lk_raddr[1] = lk_raddr1_i;

    // Operand lookup: walk oldest to youngest so the last match seen is the youngest writer
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            lk_hit[k]  = 1'b0;
            lk_slot[k] = '0;
            for (int j = 0; j < SLOTS; j++) begin
                if (lk_raddr[k] != 5'd0 &&
                    valid_q[head_q + LOG_S'(j)] &&
                    wen_q[head_q + LOG_S'(j)] &&
                    waddr_q[head_q + LOG_S'(j)] == lk_raddr[k]) begin
                    lk_hit[k]  = 1'b1;
                    lk_slot[k] = head_q + LOG_S'(j);
                end
            end
        end
    end

    assign lk_hit0_o  = lk_hit[0];
    assign lk_hit1_o  = lk_hit[1];
    assign lk_slot0_o = lk_slot[0];
    assign lk_slot1_o = lk_slot[1];
    assign lk_rdy0_o  = !pending_q[lk_slot[0]];
    assign lk_rdy1_o  = !pending_q[lk_slot[1]];
    assign lk_data0_o = data_q[lk_slot[0]];
    assign lk_data1_o = data_q[lk_slot[1]];

endmodule

// File: tb/tb_riscv_core_rob_mp.sv
// tb/tb_riscv_core_rob_mp.sv - self-checking bench for riscv_core_rob_mp
module tb_riscv_core_rob_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_val, alloc_wen, alloc_rdy;
    logic [4:0]  alloc_waddr;
    logic [3:0]  alloc_slot;
    logic [1:0]  fill_val;
    logic [7:0]  fill_slot;
    logic [63:0] fill_data;
    logic        commit_rdy, commit_val, commit_wen;
    logic [4:0]  commit_waddr;
    logic [3:0]  commit_slot;
    logic [31:0] commit_data;
    logic [4:0]  lk_raddr0, lk_raddr1;
    logic        lk_hit0, lk_hit1, lk_rdy0, lk_rdy1;
    logic [3:0]  lk_slot0, lk_slot1;
    logic [31:0] lk_data0, lk_data1;
    logic        flush, empty;
    logic [4:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    riscv_core_rob_mp #(.SLOTS(16), .LOG_S(4), .DW(32), .NFILL(2)) dut (
        .clk_i(clk), .reset_i(reset),
        .alloc_val_i(alloc_val), .alloc_rdy_o(alloc_rdy), .alloc_wen_i(alloc_wen),
        .alloc_waddr_i(alloc_waddr), .alloc_slot_o(alloc_slot),
        .fill_val_i(fill_val), .fill_slot_i(fill_slot), .fill_data_i(fill_data),
        .commit_rdy_i(commit_rdy), .commit_val_o(commit_val), .commit_wen_o(commit_wen),
        .commit_waddr_o(commit_waddr), .commit_slot_o(commit_slot), .commit_data_o(commit_data),
        .lk_raddr0_i(lk_raddr0), .lk_raddr1_i(lk_raddr1),
        .lk_hit0_o(lk_hit0), .lk_hit1_o(lk_hit1), .lk_rdy0_o(lk_rdy0), .lk_rdy1_o(lk_rdy1),
        .lk_slot0_o(lk_slot0), .lk_slot1_o(lk_slot1), .lk_data0_o(lk_data0), .lk_data1_o(lk_data1),
        .flush_i(flush), .count_o(count), .empty_o(empty)
    );

    // Reference model: the buffer is a program-ordered queue of in-flight instructions
    typedef struct {
        int        slot;
        bit        wen;
        bit [4:0]  waddr;
        bit        filled;
        bit [31:0] data;
    } ent_t;
    ent_t q[$];
    int   m_tail = 0;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endfunction

    function automatic void lookup(input bit [4:0] ra, output bit h, output int s, output bit r, output bit [31:0] d);
        h = 0; s = 0; r = 0; d = 0;
        for (int j = q.size() - 1; j >= 0; j--) begin
            if (ra != 0 && q[j].wen && q[j].waddr == ra) begin
                h = 1; s = q[j].slot; r = q[j].filled; d = q[j].data;
                break;
            end
        end
    endfunction

    task automatic model_check();
        bit cv, h, r;
        int s;
        bit [31:0] d;
        chk("m_alloc_rdy", alloc_rdy, q.size() < 16);
        chk("m_alloc_slot", alloc_slot, m_tail);
        chk("m_count", count, q.size());
        chk("m_empty", empty, q.size() == 0);
        cv = q.size() > 0 && q[0].filled;
        chk("m_commit_val", commit_val, cv);
        chk("m_commit_slot", commit_slot, q.size() > 0 ? q[0].slot : m_tail);
        if (cv) begin
            chk("m_commit_wen", commit_wen, q[0].wen);
            chk("m_commit_waddr", commit_waddr, q[0].waddr);
            chk("m_commit_data", commit_data, q[0].data);
        end
        lookup(lk_raddr0, h, s, r, d);
        chk("m_lk_hit0", lk_hit0, h);
        if (h) begin
            chk("m_lk_slot0", lk_slot0, s);
            chk("m_lk_rdy0", lk_rdy0, r);
            if (r) chk("m_lk_data0", lk_data0, d);
        end
        lookup(lk_raddr1, h, s, r, d);
        chk("m_lk_hit1", lk_hit1, h);
        if (h) begin
            chk("m_lk_slot1", lk_slot1, s);
            chk("m_lk_rdy1", lk_rdy1, r);
            if (r) chk("m_lk_data1", lk_data1, d);
        end
    endtask

    task automatic model_update();
        bit a_fire, c_fire;
        ent_t e;
        if (flush) begin
            q.delete();
            m_tail = 0;
            return;
        end
        a_fire = alloc_val && q.size() < 16;
        c_fire = q.size() > 0 && q[0].filled && commit_rdy;
        for (int i = 0; i < 2; i++) begin
            if (fill_val[i]) begin
                for (int j = 0; j < q.size(); j++) begin
                    if (q[j].slot == int'(fill_slot[i*4 +: 4])) begin
                        q[j].filled = 1;
                        q[j].data   = fill_data[i*32 +: 32];
                    end
                end
            end
        end
        if (c_fire) void'(q.pop_front());
        if (a_fire) begin
            e.slot = m_tail; e.wen = alloc_wen; e.waddr = alloc_waddr; e.filled = 0; e.data = 0;
            q.push_back(e);
            m_tail = (m_tail + 1) % 16;
        end
    endtask

    task automatic drive(input bit av, input bit aw, input bit [4:0] aa, input bit [1:0] fv,
                         input bit [3:0] fs0, input bit [31:0] fd0, input bit [3:0] fs1, input bit [31:0] fd1,
                         input bit cr, input bit fl, input bit [4:0] l0, input bit [4:0] l1);
        alloc_val = av; alloc_wen = aw; alloc_waddr = aa;
        fill_val = fv; fill_slot = {fs1, fs0}; fill_data = {fd1, fd0};
        commit_rdy = cr; flush = fl; lk_raddr0 = l0; lk_raddr1 = l1;
    endtask

    // Inputs are driven at posedge+1; outputs checked mid-cycle; model advances on the edge
    task automatic settle();
        #4;
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        bit av; bit aw; bit [4:0] aa; bit [1:0] fv;
        bit [3:0] fs0; bit [31:0] fd0; bit [3:0] fs1; bit [31:0] fd1;
        bit cr; bit fl; bit [4:0] l0; bit [4:0] l1;
        int e_cnt; int e_as; bit e_cv; bit e_cw; bit [4:0] e_cwa; bit [31:0] e_cd;
        bit e_h0; int e_s0; bit e_r0; bit [31:0] e_d0; bit e_h1;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t v(bit av, bit aw, bit [4:0] aa, bit [1:0] fv, bit [3:0] fs0, bit [31:0] fd0,
                               bit [3:0] fs1, bit [31:0] fd1, bit cr, bit fl, bit [4:0] l0, bit [4:0] l1,
                               int cnt, int as_, bit cv, bit cw, bit [4:0] cwa, bit [31:0] cd,
                               bit h0, int s0, bit r0, bit [31:0] d0, bit h1);
        vec_t x;
        x.av = av; x.aw = aw; x.aa = aa; x.fv = fv; x.fs0 = fs0; x.fd0 = fd0; x.fs1 = fs1; x.fd1 = fd1;
        x.cr = cr; x.fl = fl; x.l0 = l0; x.l1 = l1;
        x.e_cnt = cnt; x.e_as = as_; x.e_cv = cv; x.e_cw = cw; x.e_cwa = cwa; x.e_cd = cd;
        x.e_h0 = h0; x.e_s0 = s0; x.e_r0 = r0; x.e_d0 = d0; x.e_h1 = h1;
        return x;
    endfunction

    initial begin
        //            av aw aa  fv fs0 fd0       fs1 fd1      cr fl l0  l1   cnt as cv cw cwa cd        h0 s0 r0 d0       h1
        vt.push_back(v(1, 1, 5,  0, 0, 0,        0, 0,        0, 0, 5,  0,   0,  0, 0, 0, 0,  0,        0, 0, 0, 0,       0));
        vt.push_back(v(1, 1, 6,  0, 0, 0,        0, 0,        0, 0, 5,  0,   1,  1, 0, 0, 0,  0,        1, 0, 0, 0,       0));
        vt.push_back(v(1, 0, 0,  0, 0, 0,        0, 0,        0, 0, 6,  0,   2,  2, 0, 0, 0,  0,        1, 1, 0, 0,       0));
        vt.push_back(v(0, 0, 0,  1, 1, 'hAAAA,   0, 0,        1, 0, 0,  0,   3,  3, 0, 0, 0,  0,        0, 0, 0, 0,       0));
        vt.push_back(v(0, 0, 0,  2, 0, 0,        0, 'h1234,   1, 0, 6,  0,   3,  3, 0, 0, 0,  0,        1, 1, 1, 'hAAAA,  0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,        0, 0,        1, 0, 5,  0,   3,  3, 1, 1, 5,  'h1234,   1, 0, 1, 'h1234,  0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,        0, 0,        1, 0, 5,  0,   2,  3, 1, 1, 6,  'hAAAA,   0, 0, 0, 0,       0));
        vt.push_back(v(0, 0, 0,  1, 2, 'h77,     0, 0,        1, 0, 6,  0,   1,  3, 0, 0, 0,  0,        0, 0, 0, 0,       0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,        0, 0,        1, 0, 0,  0,   1,  3, 1, 0, 0,  'h77,     0, 0, 0, 0,       0));
        vt.push_back(v(1, 1, 9,  0, 0, 0,        0, 0,        0, 0, 9,  0,   0,  3, 0, 0, 0,  0,        0, 0, 0, 0,       0));
        vt.push_back(v(0, 0, 0,  3, 3, 'h11,     3, 'h22,     0, 0, 9,  0,   1,  4, 0, 0, 0,  0,        1, 3, 0, 0,       0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,        0, 0,        0, 0, 9,  0,   1,  4, 1, 1, 9,  'h22,     1, 3, 1, 'h22,    0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,        0, 0,        1, 0, 9,  0,   1,  4, 1, 1, 9,  'h22,     1, 3, 1, 'h22,    0));
        vt.push_back(v(1, 1, 7,  0, 0, 0,        0, 0,        0, 0, 7,  0,   0,  4, 0, 0, 0,  0,        0, 0, 0, 0,       0));
        vt.push_back(v(1, 1, 7,  0, 0, 0,        0, 0,        0, 0, 7,  0,   1,  5, 0, 0, 0,  0,        1, 4, 0, 0,       0));
        vt.push_back(v(0, 0, 0,  1, 4, 'h44,     0, 0,        0, 0, 7,  0,   2,  6, 0, 0, 0,  0,        1, 5, 0, 0,       0));
        vt.push_back(v(0, 0, 0,  2, 0, 0,        5, 'h55,     0, 0, 7,  0,   2,  6, 1, 1, 7,  'h44,     1, 5, 0, 0,       0));
        vt.push_back(v(1, 1, 8,  3, 9, 'hDEAD,   6, 'hBAD,    0, 0, 7,  0,   2,  6, 1, 1, 7,  'h44,     1, 5, 1, 'h55,    0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,        0, 0,        1, 0, 8,  0,   3,  7, 1, 1, 7,  'h44,     1, 6, 0, 0,       0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,        0, 0,        1, 0, 7,  0,   2,  7, 1, 1, 7,  'h55,     1, 5, 1, 'h55,    0));
        vt.push_back(v(1, 1, 10, 1, 6, 'h66,     0, 0,        1, 1, 8,  10,  1,  7, 0, 0, 0,  0,        1, 6, 0, 0,       0));
        vt.push_back(v(0, 0, 0,  0, 0, 0,        0, 0,        0, 0, 8,  10,  0,  0, 0, 0, 0,  0,        0, 0, 0, 0,       0));

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed table
        for (int n = 0; n < vt.size(); n++) begin
            drive(vt[n].av, vt[n].aw, vt[n].aa, vt[n].fv, vt[n].fs0, vt[n].fd0, vt[n].fs1, vt[n].fd1,
                  vt[n].cr, vt[n].fl, vt[n].l0, vt[n].l1);
            settle();
            chk($sformatf("v%0d_count", n), count, vt[n].e_cnt);
            chk($sformatf("v%0d_alloc_slot", n), alloc_slot, vt[n].e_as);
            chk($sformatf("v%0d_commit_val", n), commit_val, vt[n].e_cv);
            if (vt[n].e_cv) begin
                chk($sformatf("v%0d_commit_wen", n), commit_wen, vt[n].e_cw);
                chk($sformatf("v%0d_commit_waddr", n), commit_waddr, vt[n].e_cwa);
                chk($sformatf("v%0d_commit_data", n), commit_data, vt[n].e_cd);
            end
            chk($sformatf("v%0d_lk_hit0", n), lk_hit0, vt[n].e_h0);
            if (vt[n].e_h0) begin
                chk($sformatf("v%0d_lk_slot0", n), lk_slot0, vt[n].e_s0);
                chk($sformatf("v%0d_lk_rdy0", n), lk_rdy0, vt[n].e_r0);
                if (vt[n].e_r0) chk($sformatf("v%0d_lk_data0", n), lk_data0, vt[n].e_d0);
            end
            chk($sformatf("v%0d_lk_hit1", n), lk_hit1, vt[n].e_h1);
            advance();
        end

        // Fill the buffer completely, then check the full/commit/alloc corner and tail wrap
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 5'(i + 1), 0, 0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            chk("full_alloc_slot", alloc_slot, i);
            advance();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 5'd20, 3, 4'(2*i), 32'h100 + 32'(2*i), 4'(2*i+1), 32'h100 + 32'(2*i+1), 0, 0, 0, 0);
            settle();
            chk("full_alloc_rdy", alloc_rdy, 0);
            chk("full_count", count, 16);
            advance();
        end
        drive(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        settle();
        chk("full_commit_val", commit_val, 1);
        chk("full_commit_data", commit_data, 32'h100);
        chk("full_alloc_rdy_commit", alloc_rdy, 0);
        advance();
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("wrap_count", count, 15);
        chk("wrap_alloc_rdy", alloc_rdy, 1);
        chk("wrap_alloc_slot", alloc_slot, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        settle();
        chk("wrap_count_full", count, 16);
        chk("wrap_lk_hit", lk_hit0, 1);
        chk("wrap_lk_slot", lk_slot0, 0);
        chk("wrap_lk_rdy", lk_rdy0, 0);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        chk("areset_count", count, 0);
        chk("areset_empty", empty, 1);
        chk("areset_alloc_rdy", alloc_rdy, 1);
        chk("areset_commit_val", commit_val, 0);
        chk("areset_lk_hit0", lk_hit0, 0);
        q.delete();
        m_tail = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        settle();
        advance();

        // Randomized traffic against the queue model
        for (int c = 0; c < 3000; c++) begin
            bit [3:0] s0, s1;
            s0 = 4'($urandom_range(0, 15));
            s1 = 4'($urandom_range(0, 15));
            if (q.size() > 0 && $urandom_range(0, 3) != 0) s0 = 4'(q[$urandom_range(0, q.size() - 1)].slot);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) s1 = 4'(q[$urandom_range(0, q.size() - 1)].slot);
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), s0, $urandom, s1, $urandom,
                  $urandom_range(0, 99) < 65, $urandom_range(0, 63) == 0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
